sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Sole owner of the external 16-bit asynchronous SRAM bus (address, data, OE/WE, chip enables, byte enables).
- Sequences single-word read and write cycles on that bus and shares it between three requesters:
  - Q0: waveform capture writer, fixed highest priority.
  - Q1: matching engine.
  - Q2: USB readout.
- Q1 and Q2 share the remaining bandwidth round-robin.
- Replaces ad-hoc OE/WE toggling inside command-mode state machines, so no two modes can drive the bus at once.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- RD_WAIT, 2, clocks SOE_N held low before sampling SDI (min 1).
- WR_PULSE, 2, clocks SWE_N held low (min 1).

Ports:
- CLK  input  1  system clock (125 MHz).
- RST  input  1  asynchronous, active-high reset.
- Q0_REQ/Q1_REQ/Q2_REQ  input  1 each  access request; held high until the matching ACK.
- Q0_WE/Q1_WE/Q2_WE  input  1 each  1 = write, 0 = read.
- Q0_ADR/Q1_ADR/Q2_ADR  input  ADDR_W each  word address.
- Q0_WD/Q1_WD/Q2_WD  input  DATA_W each  write data.
- Q0_ACK/Q1_ACK/Q2_ACK  output  1 each  one-clock pulse: request accepted, fields latched.
- RDATA  output  DATA_W  read data.
- RVALID  output  1  one-clock pulse: RDATA valid.
- RID  output  2  requester index (0–2) owning RDATA.
- BUSY  output  1  high whenever state is not IDLE.
- SADR  output  ADDR_W  SRAM address.
- SDO  output  DATA_W  data to SRAM.
- SDOE  output  1  tri-state enable for SDO onto the data bus.
- SDI  input  DATA_W  data bus read back.
- SOE_N, SWE_N  output  1 each  SRAM output enable / write enable, active low.
- SCE1_N, SCE2, SBHE_N, SBLE_N  output  1 each  chip enables and byte enables.

Behaviour:
- Reset values (all applied asynchronously, including mid-cycle):
  - SOE_N=1, SWE_N=1, SDOE=0, SCE1_N=1, SCE2=0, SBHE_N=1, SBLE_N=1.
  - SADR=0, SDO=0, RDATA=0, RVALID=0, RID=0, all ACK=0, BUSY=0.
  - State=IDLE, round-robin pointer selects Q1 first.
  - Any access in progress is abandoned; no ACK or RVALID is produced for it afterwards.
- Out of reset: SCE1_N=0, SCE2=1, SBHE_N=0, SBLE_N=0 from the first clock edge, held constant.
- States: IDLE, RD_ADR, RD_OE, RD_END, WR_SET, WR_PULSE, WR_HOLD.
- Arbitration is evaluated only in IDLE, on every edge:
  - Any Q0_REQ=1 → Q0 wins.
  - Otherwise, if both Q1 and Q2 request, the one not served last wins; if only one requests, it wins.
  - Pointer updates only when Q1 or Q2 is granted.
- Grant edge t:
  - Winner's ACK=1 for exactly one clock.
  - SADR ← winner's ADR; RID ← winner's index.
  - On write: SDO ← WD and SDOE=1.
  - Next state: RD_ADR for a read, WR_SET for a write.
  - Losers get no ACK and keep REQ asserted.
- Read sequence:
  - RD_ADR (1 clk, address setup) → SOE_N=0 at t+1, enter RD_OE.
  - Stay in RD_OE for RD_WAIT clocks; at edge t+1+RD_WAIT: RDATA←SDI, RVALID=1, SOE_N=1, enter RD_END.
  - RD_END: RVALID=0, return to IDLE.
  - Total RD_WAIT+3 clocks from grant to next possible grant edge.
- Write sequence:
  - WR_SET (1 clk; SDOE=1, SWE_N=1) → SWE_N=0 at t+1.
  - WR_PULSE lasts WR_PULSE clocks → SWE_N=1 at t+1+WR_PULSE, enter WR_HOLD.
  - WR_HOLD: SDO/SADR held for 1 clk, then SDOE=0 and return to IDLE.
  - Total WR_PULSE+3 clocks.
- Bus invariants, checked every cycle:
  - Never SOE_N=0 together with SDOE=1.
  - Never SWE_N=0 unless SDOE=1.
  - SADR never changes while SOE_N=0 or SWE_N=0.
- Address boundary: SADR is passed through unmodified; 0xFFFFF is a valid address with no wrap logic.
- Request fields are sampled only at the grant edge; later changes do not affect the cycle in progress.
- REQ high on the same edge as a return to IDLE is arbitrated at the next edge (one IDLE clock minimum between accesses).
- Q0 can starve Q1/Q2 while it requests continuously; the capture writer duty cycle keeps this bounded by design.

Test Plan:
- Reset held 5 clocks, then released → all outputs at listed reset values during reset; SCE1_N=0, SCE2=1 one edge after release; BUSY=0.
- Q2 read at 0x00010, SDI=0xA5C3, RD_WAIT=2:
  - ACK at grant edge t.
  - SOE_N low for edges t+1..t+3.
  - RVALID=1 with RDATA=0xA5C3, RID=2 at t+3.
  - BUSY low after t+4.
- Q1 write 0x1234 to 0xFFFFF, WR_PULSE=2:
  - SDOE=1 from t.
  - SWE_N low exactly 2 clocks.
  - SADR=0xFFFFF and SDO=0x1234 stable throughout.
  - SDOE=0 at t+4.
- Q0, Q1 and Q2 all requesting (reads), each dropping REQ after its ACK → grant order Q0, Q1, Q2. Then Q1 and Q2 re-requesting continuously → alternating Q1, Q2, Q1, Q2.
- Read immediately followed by a write → bus-invariant monitor never fires; at least one clock with SOE_N=1 and SDOE=0 between SOE_N rising and SDOE rising.
- RST asserted in the second WR_PULSE clock → SWE_N=1 and SDOE=0 in the same cycle. After release, with no requests: no ACK, no RVALID, state IDLE.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Single owner of the external asynchronous SRAM bus: arbitrates three requesters
// (Q0 fixed priority, Q1/Q2 round-robin) and sequences one read or write cycle per grant.
module sram_access_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Q0_REQ,
  input  logic              Q0_WE,
  input  logic [ADDR_W-1:0] Q0_ADR,
  input  logic [DATA_W-1:0] Q0_WD,
  output logic              Q0_ACK,
  input  logic              Q1_REQ,
  input  logic              Q1_WE,
  input  logic [ADDR_W-1:0] Q1_ADR,
  input  logic [DATA_W-1:0] Q1_WD,
  output logic              Q1_ACK,
  input  logic              Q2_REQ,
  input  logic              Q2_WE,
  input  logic [ADDR_W-1:0] Q2_ADR,
  input  logic [DATA_W-1:0] Q2_WD,
  output logic              Q2_ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic [1:0]        RID,
  output logic              BUSY,
  output logic [ADDR_W-1:0] SADR,
  output logic [DATA_W-1:0] SDO,
  output logic              SDOE,
  input  logic [DATA_W-1:0] SDI,
  output logic              SOE_N,
  output logic              SWE_N,
  output logic              SCE1_N,
  output logic              SCE2,
  output logic              SBHE_N,
  output logic              SBLE_N
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ADR, ST_RD_OE, ST_RD_END, ST_WR_SET, ST_WR_PULSE, ST_WR_HOLD
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              rr_r, rr_s;
  logic [2:0]        ack_r, ack_s;
  logic [ADDR_W-1:0] sadr_r, sadr_s;
  logic [DATA_W-1:0] sdo_r, sdo_s;
  logic              sdoe_r, sdoe_s;
  logic              soe_n_r, soe_n_s;
  logic              swe_n_r, swe_n_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              rvalid_r, rvalid_s;
  logic [1:0]        rid_r, rid_s;
  logic              busy_r;
  logic              en_r;
  logic              win_vld_s;
  logic [1:0]        win_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_adr_s;
  logic [DATA_W-1:0] sel_wd_s;

  // Arbitration: Q0 always wins; rr_r=1 means Q2 is preferred on a Q1/Q2 tie
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = 2'd0;
    if (Q0_REQ) begin
      win_vld_s = 1'b1;
      win_s     = 2'd0;
    end else if (Q1_REQ && Q2_REQ) begin
      win_vld_s = 1'b1;
      win_s     = rr_r ? 2'd2 : 2'd1;
    end else if (Q1_REQ) begin
      win_vld_s = 1'b1;
      win_s     = 2'd1;
    end else if (Q2_REQ) begin
      win_vld_s = 1'b1;
      win_s     = 2'd2;
    end else begin
      win_vld_s = 1'b0;
      win_s     = 2'd0;
    end
  end

  // Request field mux for the current winner
  always_comb begin
    sel_we_s  = 1'b0;
    sel_adr_s = '0;
    sel_wd_s  = '0;
    case (win_s)
      2'd0: begin sel_we_s = Q0_WE; sel_adr_s = Q0_ADR; sel_wd_s = Q0_WD; end
      2'd1: begin sel_we_s = Q1_WE; sel_adr_s = Q1_ADR; sel_wd_s = Q1_WD; end
      2'd2: begin sel_we_s = Q2_WE; sel_adr_s = Q2_ADR; sel_wd_s = Q2_WD; end
      default: begin sel_we_s = 1'b0; sel_adr_s = '0; sel_wd_s = '0; end
    endcase
  end

  // Next-state and next-output logic for the bus sequencer
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    rr_s     = rr_r;
    ack_s    = 3'b000;
    sadr_s   = sadr_r;
    sdo_s    = sdo_r;
    sdoe_s   = sdoe_r;
    soe_n_s  = soe_n_r;
    swe_n_s  = swe_n_r;
    rdata_s  = rdata_r;
    rvalid_s = 1'b0;
    rid_s    = rid_r;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          ack_s[win_s] = 1'b1;
          sadr_s       = sel_adr_s;
          rid_s        = win_s;
          if (win_s != 2'd0) begin
            rr_s = (win_s == 2'd1);
          end else begin
            rr_s = rr_r;
          end
          if (sel_we_s) begin
            sdo_s   = sel_wd_s;
            sdoe_s  = 1'b1;
            state_s = ST_WR_SET;
          end else begin
            state_s = ST_RD_ADR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ADR: begin
        soe_n_s = 1'b0;
        cnt_s   = '0;
        state_s = ST_RD_OE;
      end
      ST_RD_OE: begin
        if (cnt_r == CNT_W'(RD_WAIT - 1)) begin
          rdata_s  = SDI;
          rvalid_s = 1'b1;
          soe_n_s  = 1'b1;
          state_s  = ST_RD_END;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_RD_END: state_s = ST_IDLE;
      ST_WR_SET: begin
        swe_n_s = 1'b0;
        cnt_s   = '0;
        state_s = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_r == CNT_W'(WR_PULSE - 1)) begin
          swe_n_s = 1'b1;
          state_s = ST_WR_HOLD;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      // Data stays driven one clock past the WE rising edge for hold time
      ST_WR_HOLD: begin
        sdoe_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        soe_n_s = 1'b1;
        swe_n_s = 1'b1;
        sdoe_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      rr_r     <= 1'b0;
      ack_r    <= 3'b000;
      sadr_r   <= '0;
      sdo_r    <= '0;
      sdoe_r   <= 1'b0;
      soe_n_r  <= 1'b1;
      swe_n_r  <= 1'b1;
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      rid_r    <= 2'd0;
      busy_r   <= 1'b0;
      en_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rr_r     <= rr_s;
      ack_r    <= ack_s;
      sadr_r   <= sadr_s;
      sdo_r    <= sdo_s;
      sdoe_r   <= sdoe_s;
      soe_n_r  <= soe_n_s;
      swe_n_r  <= swe_n_s;
      rdata_r  <= rdata_s;
      rvalid_r <= rvalid_s;
      rid_r    <= rid_s;
      busy_r   <= (state_s != ST_IDLE);
      en_r     <= 1'b1;
    end
  end

  assign Q0_ACK = ack_r[0];
  assign Q1_ACK = ack_r[1];
  assign Q2_ACK = ack_r[2];
  assign RDATA  = rdata_r;
  assign RVALID = rvalid_r;
  assign RID    = rid_r;
  assign BUSY   = busy_r;
  assign SADR   = sadr_r;
  assign SDO    = sdo_r;
  assign SDOE   = sdoe_r;
  assign SOE_N  = soe_n_r;
  assign SWE_N  = swe_n_r;
  assign SCE1_N = ~en_r;
  assign SCE2   = en_r;
  assign SBHE_N = ~en_r;
  assign SBLE_N = ~en_r;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: scoreboard queues for reads/writes,
// a per-cycle bus-invariant monitor, and directed timing/arbitration steps.
module tb_sram_access_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Q0_REQ = 1'b0, Q0_WE = 1'b0, Q0_ACK;
  logic        Q1_REQ = 1'b0, Q1_WE = 1'b0, Q1_ACK;
  logic        Q2_REQ = 1'b0, Q2_WE = 1'b0, Q2_ACK;
  logic [19:0] Q0_ADR = 20'h0, Q1_ADR = 20'h0, Q2_ADR = 20'h0;
  logic [15:0] Q0_WD = 16'h0, Q1_WD = 16'h0, Q2_WD = 16'h0;
  logic [15:0] RDATA, SDO, SDI;
  logic        RVALID, BUSY, SDOE, SOE_N, SWE_N, SCE1_N, SCE2, SBHE_N, SBLE_N;
  logic [1:0]  RID;
  logic [19:0] SADR;

  int total = 0;
  int bad   = 0;

  logic [17:0] rd_q[$];
  logic [35:0] wr_q[$];

  always #5 CLK = ~CLK;

  function automatic logic [15:0] mem_model(input logic [19:0] a);
    return a[15:0] ^ 16'hA5D3;
  endfunction

  assign SDI = mem_model(SADR);

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .RD_WAIT(2), .WR_PULSE(2)) dut (
    .CLK(CLK), .RST(RST),
    .Q0_REQ(Q0_REQ), .Q0_WE(Q0_WE), .Q0_ADR(Q0_ADR), .Q0_WD(Q0_WD), .Q0_ACK(Q0_ACK),
    .Q1_REQ(Q1_REQ), .Q1_WE(Q1_WE), .Q1_ADR(Q1_ADR), .Q1_WD(Q1_WD), .Q1_ACK(Q1_ACK),
    .Q2_REQ(Q2_REQ), .Q2_WE(Q2_WE), .Q2_ADR(Q2_ADR), .Q2_WD(Q2_WD), .Q2_ACK(Q2_ACK),
    .RDATA(RDATA), .RVALID(RVALID), .RID(RID), .BUSY(BUSY),
    .SADR(SADR), .SDO(SDO), .SDOE(SDOE), .SDI(SDI),
    .SOE_N(SOE_N), .SWE_N(SWE_N), .SCE1_N(SCE1_N), .SCE2(SCE2),
    .SBHE_N(SBHE_N), .SBLE_N(SBLE_N)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Bus invariants and scoreboard pops, sampled mid-cycle
  logic        prev_soe_n = 1'b1, prev_swe_n = 1'b1, prev_rst = 1'b1;
  logic [19:0] prev_sadr  = 20'h0;
  always @(negedge CLK) begin
    if (!RST) begin
      chk("inv_oe_with_sdoe", 48'(!SOE_N && SDOE), 48'(0));
      chk("inv_we_without_sdoe", 48'(!SWE_N && !SDOE), 48'(0));
      if (!prev_rst && (!prev_soe_n || !prev_swe_n))
        chk("sadr_stable", 48'(SADR), 48'(prev_sadr));
      if (!prev_rst && !prev_swe_n && SWE_N) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 48'(1), 48'(0));
        else chk("wr_sb", 48'({SADR, SDO}), 48'(wr_q.pop_front()));
      end
      if (RVALID) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 48'(1), 48'(0));
        else chk("rd_sb", 48'({RID, RDATA}), 48'(rd_q.pop_front()));
      end
    end
    prev_soe_n = SOE_N;
    prev_swe_n = SWE_N;
    prev_rst   = RST;
    prev_sadr  = SADR;
  end

  initial begin
    int order[$];
    int lows;
    int gap;
    logic seen_rise, done, prev_soe;

    // Reset held 5 clocks
    repeat (5) step();
    chk("rst_strobes", 48'({SOE_N, SWE_N, SDOE, SCE1_N, SCE2, SBHE_N, SBLE_N}), 48'(7'b1101011));
    chk("rst_sadr_sdo", 48'({SADR, SDO}), 48'(0));
    chk("rst_rd", 48'({RDATA, RVALID, RID}), 48'(0));
    chk("rst_ack_busy", 48'({Q0_ACK, Q1_ACK, Q2_ACK, BUSY}), 48'(0));
    RST = 1'b0;
    step();
    chk("ce_after_rst", 48'({SCE1_N, SCE2, SBHE_N, SBLE_N}), 48'(4'b0100));
    chk("busy_after_rst", 48'(BUSY), 48'(0));

    // Q2 read at 0x00010
    Q2_REQ = 1'b1; Q2_WE = 1'b0; Q2_ADR = 20'h00010;
    rd_q.push_back({2'd2, mem_model(20'h00010)});
    step();
    chk("q2_ack", 48'({Q0_ACK, Q1_ACK, Q2_ACK}), 48'(3'b001));
    chk("q2_grant_bus", 48'({SADR, RID, SOE_N, BUSY}), 48'({20'h00010, 2'd2, 1'b1, 1'b1}));
    Q2_REQ = 1'b0; Q2_ADR = 20'h0BEEF;
    step();
    chk("rd_t1", 48'({SOE_N, Q2_ACK, RVALID}), 48'(3'b000));
    step();
    chk("rd_t2", 48'({SOE_N, RVALID, SADR}), 48'({1'b0, 1'b0, 20'h00010}));
    step();
    chk("rd_t3", 48'({RVALID, RID, RDATA, SOE_N}), 48'({1'b1, 2'd2, 16'hA5C3, 1'b1}));
    step();
    chk("rd_t4", 48'({RVALID, BUSY}), 48'(2'b00));

    // All three request reads; expected grant order Q0, Q1, Q2
    Q0_REQ = 1'b1; Q0_ADR = 20'h00100;
    Q1_REQ = 1'b1; Q1_WE = 1'b0; Q1_ADR = 20'h00200;
    Q2_REQ = 1'b1; Q2_ADR = 20'h00300;
    rd_q.push_back({2'd0, mem_model(20'h00100)});
    rd_q.push_back({2'd1, mem_model(20'h00200)});
    rd_q.push_back({2'd2, mem_model(20'h00300)});
    for (int i = 0; i < 60 && order.size() < 3; i++) begin
      step();
      if (Q0_ACK) begin order.push_back(0); Q0_REQ = 1'b0; end
      if (Q1_ACK) begin order.push_back(1); Q1_REQ = 1'b0; end
      if (Q2_ACK) begin order.push_back(2); Q2_REQ = 1'b0; end
    end
    for (int k = 0; k < 3; k++)
      chk("prio_order", 48'((k < order.size()) ? order[k] : 9), 48'(k));

    // Q1 and Q2 continuously requesting: alternate 1,2,1,2
    order.delete();
    Q1_REQ = 1'b1; Q1_ADR = 20'h00400;
    Q2_REQ = 1'b1; Q2_ADR = 20'h00500;
    rd_q.push_back({2'd1, mem_model(20'h00400)});
    rd_q.push_back({2'd2, mem_model(20'h00500)});
    rd_q.push_back({2'd1, mem_model(20'h00400)});
    rd_q.push_back({2'd2, mem_model(20'h00500)});
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      step();
      if (Q1_ACK) order.push_back(1);
      if (Q2_ACK) order.push_back(2);
      if (order.size() >= 4) begin Q1_REQ = 1'b0; Q2_REQ = 1'b0; end
    end
    Q1_REQ = 1'b0; Q2_REQ = 1'b0;
    for (int k = 0; k < 4; k++)
      chk("rr_order", 48'((k < order.size()) ? order[k] : 9), 48'((k % 2 == 0) ? 1 : 2));
    for (int i = 0; i < 40 && BUSY; i++) step();
    chk("idle_after_rr", 48'(BUSY), 48'(0));

    // Q1 write 0x1234 to 0xFFFFF
    Q1_REQ = 1'b1; Q1_WE = 1'b1; Q1_ADR = 20'hFFFFF; Q1_WD = 16'h1234;
    wr_q.push_back({20'hFFFFF, 16'h1234});
    step();
    chk("q1_ack", 48'({Q0_ACK, Q1_ACK, Q2_ACK}), 48'(3'b010));
    chk("wr_grant", 48'({SDOE, SWE_N, SADR, SDO}), 48'({1'b1, 1'b1, 20'hFFFFF, 16'h1234}));
    Q1_REQ = 1'b0; Q1_ADR = 20'h0; Q1_WD = 16'hFFFF;
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!SWE_N) lows++;
      chk("wr_bus_hold", 48'({SDOE, SADR, SDO}), 48'({1'b1, 20'hFFFFF, 16'h1234}));
    end
    chk("swe_low_clocks", 48'(lows), 48'(2));
    step();
    chk("wr_t4", 48'({SDOE, SWE_N, BUSY}), 48'(3'b010));

    // Read (Q2) followed immediately by write (Q1)
    Q2_REQ = 1'b1; Q2_WE = 1'b0; Q2_ADR = 20'h12345;
    Q1_REQ = 1'b1; Q1_WE = 1'b1; Q1_ADR = 20'h00777; Q1_WD = 16'hCAFE;
    rd_q.push_back({2'd2, mem_model(20'h12345)});
    wr_q.push_back({20'h00777, 16'hCAFE});
    order.delete();
    gap = 0; seen_rise = 1'b0; done = 1'b0; prev_soe = SOE_N;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (Q1_ACK) begin order.push_back(1); Q1_REQ = 1'b0; end
      if (Q2_ACK) begin order.push_back(2); Q2_REQ = 1'b0; end
      if (!prev_soe && SOE_N) seen_rise = 1'b1;
      if (seen_rise) begin
        if (SDOE) done = 1'b1;
        else if (SOE_N) gap++;
      end
      prev_soe = SOE_N;
    end
    chk("rw_write_started", 48'(done), 48'(1));
    chk("rw_gap", 48'(gap >= 1), 48'(1));
    chk("rw_order", 48'((order.size() == 2) ? (order[0] * 10 + order[1]) : 0), 48'(21));
    for (int i = 0; i < 40 && BUSY; i++) step();
    chk("idle_after_rw", 48'(BUSY), 48'(0));

    // Reset during the second WR_PULSE clock
    Q1_REQ = 1'b1; Q1_WE = 1'b1; Q1_ADR = 20'h00ABC; Q1_WD = 16'hBEEF;
    step();
    chk("q1_ack_abort", 48'(Q1_ACK), 48'(1));
    Q1_REQ = 1'b0;
    step();
    step();
    chk("swe_low_before_rst", 48'({SWE_N, SDOE}), 48'(2'b01));
    RST = 1'b1;
    #1;
    chk("rst_mid_wr", 48'({SWE_N, SDOE, BUSY}), 48'(3'b100));
    wr_q.delete();
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_quiet", 48'({Q0_ACK, Q1_ACK, Q2_ACK, RVALID, BUSY}), 48'(0));
    end

    chk("rd_q_drained", 48'(rd_q.size()), 48'(0));
    chk("wr_q_drained", 48'(wr_q.size()), 48'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
